lane_stripe_ctrl: RTL and testbench

- Scheduler that stripes one incoming byte stream across two physical lanes for the PCIe transmit path.
- Decides per byte which lane receives it: round-robin when both lanes are enabled, fixed when only one is enabled.
- Buffers each lane in a small show-ahead FIFO with valid/ready handshakes on every side.
- Replaces the free-running selector toggle with a flow-controlled, lane-enable-aware sequencer.

---
 rtl/lane_stripe_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_lane_stripe_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_stripe_ctrl.sv
// Two-lane byte striper: steers each accepted byte into one of two show-ahead
// lane FIFOs, round-robin when both lanes are enabled, fixed otherwise.

module lane_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [DATA_W-1:0]                push_data,
    input  logic                             pop,
    output logic [DATA_W-1:0]                head,
    output logic                             valid,
    output logic                             full,
    output logic [$clog2(DEPTH+1)-1:0]       level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              empty_s;

    // Occupancy flags come from the level counter, never from pointer compare.
    always_comb begin
        empty_s   = (level_r == {LVL_W{1'b0}});
        full      = (level_r == LVL_W'(DEPTH));
        valid     = !empty_s;
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty_s;
        head      = mem_r[rd_ptr_r];
        level     = level_r;
    end

    // Storage array; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks push/pop combinations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

module lane_stripe_ctrl_chk #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                              clk,
    input logic                              reset,
    input logic                              in_valid,
    input logic                              in_ready,
    input logic [1:0]                        lane_en,
    input logic                              target_lane,
    input logic                              out0_valid,
    input logic                              out1_valid,
    input logic [$clog2(FIFO_DEPTH+1)-1:0]   lvl0,
    input logic [$clog2(FIFO_DEPTH+1)-1:0]   lvl1
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    a_lvl0_bound: assert property (@(posedge clk) disable iff (reset)
        lvl0 <= LVL_W'(FIFO_DEPTH));
    a_lvl1_bound: assert property (@(posedge clk) disable iff (reset)
        lvl1 <= LVL_W'(FIFO_DEPTH));
    a_valid0_lvl: assert property (@(posedge clk) disable iff (reset)
        out0_valid == (lvl0 != {LVL_W{1'b0}}));
    a_valid1_lvl: assert property (@(posedge clk) disable iff (reset)
        out1_valid == (lvl1 != {LVL_W{1'b0}}));
    a_accept_enabled: assert property (@(posedge clk) disable iff (reset)
        (in_valid && in_ready) |-> lane_en[target_lane]);
endmodule

module lane_stripe_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        lane_en,
    output logic [DATA_W-1:0]                 out0_data,
    output logic                              out0_valid,
    input  logic                              out0_ready,
    output logic [DATA_W-1:0]                 out1_data,
    output logic                              out1_valid,
    input  logic                              out1_ready,
    output logic                              target_lane,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   lvl0,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   lvl1
);
    logic [1:0] lane_en_q_r;
    logic       rr_r;
    logic       rr_next_s;
    logic       full0_s;
    logic       full1_s;
    logic       tgt_full_s;
    logic       accept_s;
    logic       push0_s;
    logic       push1_s;
    logic       realign_s;

    // Lane choice for the byte that would be accepted this cycle.
    always_comb begin
        target_lane = 1'b0;
        case (lane_en)
            2'b11:   target_lane = rr_r;
            2'b01:   target_lane = 1'b0;
            2'b10:   target_lane = 1'b1;
            default: target_lane = 1'b0;
        endcase
    end

    // Backpressure looks only at the target lane's stored level, so a pop in
    // the same cycle never frees a slot for a push (no pass-through).
    always_comb begin
        if (target_lane) begin
            tgt_full_s = full1_s;
        end else begin
            tgt_full_s = full0_s;
        end
        in_ready  = (lane_en != 2'b00) && !tgt_full_s;
        accept_s  = in_valid && in_ready;
        push0_s   = accept_s && !target_lane;
        push1_s   = accept_s && target_lane;
        realign_s = (lane_en != lane_en_q_r);
    end

    // A lane-enable change restarts striping at lane 0, winning over a toggle.
    always_comb begin
        if (realign_s) begin
            rr_next_s = 1'b0;
        end else if (accept_s && (lane_en == 2'b11)) begin
            rr_next_s = !rr_r;
        end else begin
            rr_next_s = rr_r;
        end
    end

    // Round-robin pointer and registered lane-enable copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_r        <= 1'b0;
            lane_en_q_r <= 2'b00;
        end else begin
            rr_r        <= rr_next_s;
            lane_en_q_r <= lane_en;
        end
    end

    lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0_s),
        .push_data (in_data),
        .pop       (out0_ready),
        .head      (out0_data),
        .valid     (out0_valid),
        .full      (full0_s),
        .level     (lvl0)
    );

    lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1_s),
        .push_data (in_data),
        .pop       (out1_ready),
        .head      (out1_data),
        .valid     (out1_valid),
        .full      (full1_s),
        .level     (lvl1)
    );

    lane_stripe_ctrl_chk #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lane_en     (lane_en),
        .target_lane (target_lane),
        .out0_valid  (out0_valid),
        .out1_valid  (out1_valid),
        .lvl0        (lvl0),
        .lvl1        (lvl1)
    );
endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Directed bench for lane_stripe_ctrl: expected bytes are queued per lane at
// accept time and a negedge monitor compares them as each lane pops.

module tb_lane_stripe_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] lane_en;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic       target_lane;
    logic [2:0] lvl0;
    logic [2:0] lvl1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp0_v;
    logic [7:0] exp1_v;

    always #5 clk = ~clk;

    lane_stripe_ctrl #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lane_en     (lane_en),
        .out0_data   (out0_data),
        .out0_valid  (out0_valid),
        .out0_ready  (out0_ready),
        .out1_data   (out1_data),
        .out1_valid  (out1_valid),
        .out1_ready  (out1_ready),
        .target_lane (target_lane),
        .lvl0        (lvl0),
        .lvl1        (lvl1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one byte; on acceptance queue it on the hand-computed lane.
    task automatic send(input logic [7:0] d, input logic exp_lane, input bit lat);
        int  waited = 0;
        bit  done   = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                chk("target_lane", target_lane, exp_lane);
                if (exp_lane) exp_q1.push_back(d);
                else          exp_q0.push_back(d);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%0h never accepted within 50 cycles", d);
        end else if (lat) begin
            if (exp_lane) begin
                chk("latency_valid1", out1_valid, 1);
                chk("latency_data1", out1_data, d);
            end else begin
                chk("latency_valid0", out0_valid, 1);
                chk("latency_data0", out0_data, d);
            end
        end
    endtask

    // Scoreboard monitor: every handshake on an output lane pops and compares.
    always @(negedge clk) begin
        if (!reset && out0_valid && out0_ready) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lane0_unexpected: got 0x%0h expected nothing", out0_data);
            end else begin
                exp0_v = exp_q0.pop_front();
                chk("lane0_data", out0_data, exp0_v);
            end
        end
        if (!reset && out1_valid && out1_ready) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lane1_unexpected: got 0x%0h expected nothing", out1_data);
            end else begin
                exp1_v = exp_q1.pop_front();
                chk("lane1_data", out1_data, exp1_v);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        lane_en    = 2'b11;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step(3);
        chk("rst_lvl0", lvl0, 0);
        chk("rst_lvl1", lvl1, 0);
        chk("rst_valid0", out0_valid, 0);
        chk("rst_valid1", out1_valid, 0);
        chk("rst_data0", out0_data, 0);
        chk("rst_data1", out1_data, 0);
        reset = 1'b0;
        step(2);
        chk("rr_after_reset", target_lane, 0);

        // Basic round-robin striping, one-cycle latency.
        send(8'h10, 1'b0, 1'b1);
        send(8'h11, 1'b1, 1'b1);
        send(8'h12, 1'b0, 1'b1);
        send(8'h13, 1'b1, 1'b1);
        step(3);

        // Lane 1 stalled: it fills to four, then blocks its next byte.
        out1_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(8'h20 + 8'(i), i[0], 1'b0);
        end
        chk("full_lvl1", lvl1, 4);
        in_data  = 8'h29;
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_target", target_lane, 1);
        chk("full_lvl1_hold", lvl1, 4);
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        send(8'h29, 1'b1, 1'b0);
        step(8);

        // Single lane 0.
        lane_en = 2'b01;
        step(2);
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 1'b0, 1'b1);
            chk("lane0_only_lvl1", lvl1, 0);
        end
        chk("lane0_only_target", target_lane, 0);
        step(3);

        // Realignment after leaving and re-entering dual-lane mode.
        lane_en = 2'b11;
        step(2);
        send(8'hC0, 1'b0, 1'b0);
        send(8'hC1, 1'b1, 1'b0);
        send(8'hC2, 1'b0, 1'b0);
        chk("rr_odd", target_lane, 1);
        lane_en = 2'b10;
        step(2);
        chk("lane1_only_target", target_lane, 1);
        lane_en = 2'b11;
        step(2);
        chk("realign_target", target_lane, 0);
        send(8'hB0, 1'b0, 1'b0);
        send(8'hB1, 1'b1, 1'b0);
        step(4);

        // No lanes enabled: nothing accepted.
        lane_en  = 2'b00;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("none_in_ready", in_ready, 0);
            chk("none_lvl0", lvl0, 0);
            chk("none_lvl1", lvl1, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Asynchronous reset with lane 0 holding three bytes.
        lane_en = 2'b01;
        step(2);
        out0_ready = 1'b0;
        send(8'hD0, 1'b0, 1'b0);
        send(8'hD1, 1'b0, 1'b0);
        send(8'hD2, 1'b0, 1'b0);
        chk("pre_reset_lvl0", lvl0, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid0", out0_valid, 0);
        chk("async_lvl0", lvl0, 0);
        chk("async_data0", out0_data, 0);
        exp_q0.delete();
        exp_q1.delete();
        step(2);
        reset      = 1'b0;
        out0_ready = 1'b1;
        lane_en    = 2'b11;
        step(2);
        chk("post_reset_lvl0", lvl0, 0);
        chk("post_reset_valid0", out0_valid, 0);
        chk("post_reset_rr", target_lane, 0);
        send(8'hE0, 1'b0, 1'b1);
        send(8'hE1, 1'b1, 1'b1);
        step(4);

        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
